timer_multi: RTL and testbench

//  Parametrised multi-channel count-up timer on the RIB peripheral bus; successor to the single 32-bit timer.

---
 rtl/timer_multi.sv | 71 +++++++
 tb/tb_timer_multi.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// timer_multi: multi-channel prescaled count-up timer with W1C status and a combined level interrupt
module timer_multi #(
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 32,
  parameter int PSC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic        req_i,
  output logic [31:0] data_o,
  output logic        int_sig_o,
  output logic        ack_o
);
  logic              wr;
  logic              status_hit;
  logic [1:0]        off;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] irq_v;
  logic [31:0]       rdata [NUM_CH];
  logic              unused_addr;
  assign unused_addr = ^addr_i[31:12];
  assign wr          = req_i & we_i;
  assign off         = addr_i[3:2];
  assign status_hit  = addr_i[11:0] == 12'h100;
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic               en, ie, pend, mode;
    logic [COUNT_W-1:0] count, value;
    logic [PSC_W-1:0]   psc, psc_cnt;
    logic               tick, match, ctl_w, cnt_w, val_w, psc_w, clr;
    assign hit[n] = addr_i[1:0] == 2'b00 && addr_i[11:4] == 8'(n);
    assign ctl_w  = wr & hit[n] & (off == 2'd0);
    assign cnt_w  = wr & hit[n] & (off == 2'd1);
    assign val_w  = wr & hit[n] & (off == 2'd2);
    assign psc_w  = wr & hit[n] & (off == 2'd3);
    assign clr    = (ctl_w & data_i[2]) | (wr & status_hit & data_i[n]);
    assign tick   = en & (psc_cnt == psc);
    assign match  = tick & (count == value);
    always_ff @(posedge clk)
      if (!rst) begin
        en <= 1'b0; ie <= 1'b0; pend <= 1'b0; mode <= 1'b0;
        count <= '0; value <= '0; psc <= '0; psc_cnt <= '0;
      end else begin
        psc_cnt <= (!en || tick) ? '0 : psc_cnt + PSC_W'(1);
        count   <= cnt_w ? data_i[COUNT_W-1:0] : tick ? (match ? '0 : count + COUNT_W'(1)) : count;
        pend    <= match | (pend & ~clr);
        en      <= (match & mode) ? 1'b0 : ctl_w ? data_i[0] : en;
        ie      <= ctl_w ? data_i[1] : ie;
        mode    <= ctl_w ? data_i[3] : mode;
        value   <= val_w ? data_i[COUNT_W-1:0] : value;
        psc     <= psc_w ? data_i[PSC_W-1:0] : psc;
      end
    assign pend_v[n] = pend;
    assign irq_v[n]  = pend & ie;
    assign rdata[n]  = off == 2'd0 ? {28'd0, mode, pend, ie, en} :
                       off == 2'd1 ? 32'(count) :
                       off == 2'd2 ? 32'(value) : 32'(psc);
  end
  always_comb begin
    data_o = status_hit ? 32'(pend_v) : '0;
    for (int i = 0; i < NUM_CH; i++)
      if (hit[i]) data_o = rdata[i];
    if (!rst) data_o = '0;
  end
  assign int_sig_o = |irq_v;
  always_ff @(posedge clk)
    ack_o <= rst ? req_i : 1'b0;
endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: directed checks of timer_multi timing, W1C, one-shot, wrap and reset
module tb_timer_multi;
  logic        clk, rst, we_i, req_i, int_sig_o, ack_o;
  logic [31:0] data_i, addr_i, data_o;
  int checks = 0;
  int errors = 0;

  timer_multi dut (
    .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i), .we_i(we_i),
    .req_i(req_i), .data_o(data_o), .int_sig_o(int_sig_o), .ack_o(ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // called at a negedge; the write lands on the following posedge and returns at the next negedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic chkrd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    #1 chk(tag, data_o, exp);
  endtask

  initial begin
    rst = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h4; data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_int", {31'd0, int_sig_o}, 32'd0);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    rst = 1'b1;
    chkrd("rst_ctrl0", 32'h000, 32'd0);
    chkrd("rst_status", 32'h100, 32'd0);

    // ch0 VALUE=3 PSC=0: match 4 cycles after enable
    wr(32'h008, 32'd3);
    chk("ack_hi", {31'd0, ack_o}, 32'd1);
    chkrd("ch0_value", 32'h008, 32'd3);
    wr(32'h000, 32'h3);
    repeat (3) @(negedge clk);
    chk("t1_int_early", {31'd0, int_sig_o}, 32'd0);
    chk("ack_lo", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    chk("t1_int", {31'd0, int_sig_o}, 32'd1);
    chkrd("t1_count", 32'h004, 32'd0);
    chkrd("t1_ctrl", 32'h000, 32'h7);
    wr(32'h000, 32'h4);
    chk("t1_int_clr", {31'd0, int_sig_o}, 32'd0);

    // ch1 VALUE=1 PSC=2 periodic: period 6, STATUS W1C
    wr(32'h018, 32'd1);
    wr(32'h01C, 32'd2);
    wr(32'h010, 32'h3);
    repeat (5) @(negedge clk);
    chkrd("t2_status_early", 32'h100, 32'd0);
    @(negedge clk);
    chkrd("t2_status", 32'h100, 32'h2);
    chk("t2_int", {31'd0, int_sig_o}, 32'd1);
    wr(32'h100, 32'h2);
    chkrd("t2_status_clr", 32'h100, 32'd0);
    chk("t2_int_drop", {31'd0, int_sig_o}, 32'd0);
    repeat (4) @(negedge clk);
    chkrd("t2_status_early2", 32'h100, 32'd0);
    @(negedge clk);
    chkrd("t2_status2", 32'h100, 32'h2);
    wr(32'h010, 32'h4);

    // software clear on the very edge of a hardware match: set wins
    wr(32'h010, 32'h3);
    repeat (5) @(negedge clk);
    wr(32'h100, 32'h2);
    chkrd("t4_pend_kept", 32'h100, 32'h2);
    wr(32'h010, 32'h4);
    chkrd("t4_cleared", 32'h100, 32'd0);

    // ch2 one-shot VALUE=5
    wr(32'h028, 32'd5);
    wr(32'h020, 32'hB);
    repeat (5) @(negedge clk);
    chkrd("t3_ctrl_run", 32'h020, 32'hB);
    @(negedge clk);
    chkrd("t3_ctrl_done", 32'h020, 32'hE);
    chk("t3_int", {31'd0, int_sig_o}, 32'd1);
    repeat (20) @(negedge clk);
    chkrd("t3_count_hold", 32'h024, 32'd0);
    chkrd("t3_status", 32'h100, 32'h4);
    wr(32'h020, 32'h4);

    // ch3 wrap from 0xFFFFFFF0 to VALUE=2: 19 ticks, IE off
    wr(32'h038, 32'd2);
    wr(32'h034, 32'hFFFF_FFF0);
    wr(32'h030, 32'h1);
    repeat (18) @(negedge clk);
    chkrd("t5_status_early", 32'h100, 32'd0);
    @(negedge clk);
    chkrd("t5_status", 32'h100, 32'h8);
    chk("t5_int_masked", {31'd0, int_sig_o}, 32'd0);
    wr(32'h034, 32'd100);
    chkrd("t5_write_wins", 32'h034, 32'd100);
    @(negedge clk);
    chkrd("t5_count_next", 32'h034, 32'd101);
    wr(32'h030, 32'h4);

    // unmapped offsets
    wr(32'h200, 32'hDEAD_BEEF);
    chkrd("unmapped_200", 32'h200, 32'd0);
    chkrd("unmapped_104", 32'h104, 32'd0);
    chkrd("unmapped_ch4", 32'h040, 32'd0);

    // reset while every channel runs
    wr(32'h000, 32'h3);
    wr(32'h010, 32'h3);
    wr(32'h020, 32'h3);
    wr(32'h030, 32'h3);
    repeat (8) @(negedge clk);
    chk("t6_int_pre", {31'd0, int_sig_o}, 32'd1);
    req_i = 1'b1; addr_i = 32'h004; rst = 1'b0;
    @(negedge clk);
    chk("t6_int", {31'd0, int_sig_o}, 32'd0);
    chk("t6_ack", {31'd0, ack_o}, 32'd0);
    chk("t6_data", data_o, 32'd0);
    rst = 1'b1; req_i = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int o = 0; o < 4; o++)
        chkrd($sformatf("t6_reg_%0d_%0d", c, o), 32'(c * 16 + o * 4), 32'd0);
    chkrd("t6_status", 32'h100, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
